// File: rtl/pipelined_adder_pkg.sv
// Shared constants and stage-register control fields for the pipelined adder.
// Define PIPELINED_ADDER_DBG_EN to enable the per-chunk carry debug port.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_STAGE_W = 4;

  function automatic int n_stg(input int width, input int stage_w);
    return width / stage_w;
  endfunction

  // Width-independent part of a stage register; the WIDTH-sized sum and
  // operand fields are wrapped around it inside the parameterised top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctrl_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The master drives operands and out_ready; the slave is the adder itself.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder resolving one pipeline stage's chunk.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int W = DEFAULT_STAGE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of each chunk's ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGE_W-bit registered stages.
// Define PIPELINED_ADDER_DBG_EN to add dbg_carry, the per-chunk carries of the result on sum.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int STAGE_W = DEFAULT_STAGE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_adder_if.slave    bus
`ifdef PIPELINED_ADDER_DBG_EN
  ,
  output logic [n_stg(WIDTH, STAGE_W)-1:0] dbg_carry
`endif
);

  localparam int N_STG = n_stg(WIDTH, STAGE_W);

  if (WIDTH % STAGE_W != 0) begin : g_width_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGE_W");
  end

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           q [N_STG];
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe moves in lockstep; bubbles are kept so latency stays fixed.
  assign advance      = bus.out_ready || !q[N_STG-1].ctrl.valid;
  assign bus.in_ready = advance;

  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.cin ^ bus.sub;

`ifdef PIPELINED_ADDER_DBG_EN
  logic [N_STG-1:0] dbg_q [N_STG];
  assign dbg_carry = dbg_q[N_STG-1];
`endif

  for (genvar k = 0; k < N_STG; k++) begin : g_stage
    stage_t             prev;
    stage_t             nxt;
    logic [STAGE_W-1:0] chunk_sum;
    logic               chunk_cout;

    if (k == 0) begin : g_first
      assign prev = '{
        ctrl: '{valid: bus.in_valid, carry: c_eff,
                a_msb: bus.a[WIDTH-1], b_msb: b_eff[WIDTH-1]},
        sum:  '0,
        a:    bus.a,
        b:    b_eff
      };
    end else begin : g_next
      assign prev = q[k-1];
    end

    adder_chunk #(.W(STAGE_W)) u_chunk (
      .a    (prev.a[k*STAGE_W +: STAGE_W]),
      .b    (prev.b[k*STAGE_W +: STAGE_W]),
      .cin  (prev.ctrl.carry),
      .sum  (chunk_sum),
      .cout (chunk_cout)
    );

    always_comb begin
      nxt                            = prev;
      nxt.sum[k*STAGE_W +: STAGE_W]  = chunk_sum;
      nxt.ctrl.carry                 = chunk_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q[k] <= '0;
      end else if (advance) begin
        q[k] <= nxt;
      end
    end

`ifdef PIPELINED_ADDER_DBG_EN
    logic [N_STG-1:0] dbg_d;

    if (k == 0) begin : g_dbg_first
      always_comb begin
        dbg_d    = '0;
        dbg_d[k] = chunk_cout;
      end
    end else begin : g_dbg_next
      always_comb begin
        dbg_d    = dbg_q[k-1];
        dbg_d[k] = chunk_cout;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dbg_q[k] <= '0;
      end else if (advance) begin
        dbg_q[k] <= dbg_d;
      end
    end
`endif
  end

  assign bus.out_valid = q[N_STG-1].ctrl.valid;
  assign bus.sum       = q[N_STG-1].sum;
  assign bus.cout      = q[N_STG-1].ctrl.carry;
  assign bus.ovf       = (q[N_STG-1].ctrl.a_msb == q[N_STG-1].ctrl.b_msb) &&
                         (q[N_STG-1].sum[WIDTH-1] != q[N_STG-1].ctrl.a_msb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vector table, stall/reset sequences and random streams
// against an arithmetic reference model; also exercises a single-stage 8-bit instance.
module tb_pipelined_adder;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

`ifdef PIPELINED_ADDER_DBG_EN
  logic [3:0] dbg16;
  logic [0:0] dbg8;
`endif

  pipelined_adder #(.WIDTH(16), .STAGE_W(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
`ifdef PIPELINED_ADDER_DBG_EN
    ,
    .dbg_carry (dbg16)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGE_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
`ifdef PIPELINED_ADDER_DBG_EN
    ,
    .dbg_carry (dbg8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  dbg;
  } exp_t;

  vec_t vecs [8];

  // Reference: true signed/unsigned results of a+b+cin or a-b-cin, no carry chain.
  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
    exp_t        e;
    int          sa, sb, ci, ideal, ce;
    longint      ua, ub, beff, m, part;
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    ci    = int'(cin);
    ua    = longint'(a);
    ub    = longint'(b);
    ideal = sub ? (sa - sb - ci) : (sa + sb + ci);
    e.sum  = ideal[15:0];
    e.ovf  = (ideal > 32767) || (ideal < -32768);
    e.cout = sub ? (ua >= ub + ci) : ((ua + ub + ci) > 65535);
    beff  = sub ? (65535 - ub) : ub;
    ce    = sub ? 1 - ci : ci;
    for (int k = 0; k < 4; k++) begin
      m    = (longint'(1) << (4 * (k + 1))) - 1;
      part = (ua & m) + (beff & m) + ce;
      e.dbg[k] = ((part >> (4 * (k + 1))) & 1) != 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    int ok    = 0;
    int tries = 0;
    @(negedge clk);
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    bus16.sub      = sub;
    bus16.in_valid = 1'b1;
    while (!ok && tries < 50) begin
      #4;
      if (bus16.in_ready) ok = 1;
      @(posedge clk);
      tries++;
      if (!ok) @(negedge clk);
    end
    #1 bus16.in_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      #4;
      lat++;
    end while (!bus16.out_valid && lat < 50);
  endtask

  // mode 0: out_ready alternates 1,0,...; mode 1: random out_ready and input gaps.
  task automatic runStream(input int n, input int mode);
    exp_t        expq [$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    logic        have = 1'b0, held = 1'b0;
    logic [15:0] hs;
    logic        hc, ho;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      bus16.out_ready = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (!have && sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
        bus16.a   = 16'($urandom);
        bus16.b   = 16'($urandom);
        bus16.cin = 1'($urandom_range(0, 1));
        bus16.sub = 1'($urandom_range(0, 1));
        have      = 1'b1;
      end
      bus16.in_valid = have;
      #4;
      if (held) begin
        checkOutput("stall_valid", bus16.out_valid, 1);
        checkOutput("stall_sum", bus16.sum, hs);
        checkOutput("stall_cout", bus16.cout, hc);
        checkOutput("stall_ovf", bus16.ovf, ho);
      end
      held = bus16.out_valid && !bus16.out_ready;
      hs   = bus16.sum;
      hc   = bus16.cout;
      ho   = bus16.ovf;
      if (bus16.out_valid && bus16.out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("stream_sum", bus16.sum, e.sum);
          checkOutput("stream_cout", bus16.cout, e.cout);
          checkOutput("stream_ovf", bus16.ovf, e.ovf);
`ifdef PIPELINED_ADDER_DBG_EN
          checkOutput("stream_dbg", dbg16, e.dbg);
`endif
        end
        got++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        expq.push_back(model16(bus16.a, bus16.b, bus16.cin, bus16.sub));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    checkOutput("stream_count", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    int   seen;
    exp_t e;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n           = 1'b0;
    bus16.in_valid  = 1'b1;
    bus16.a         = 16'h1234;
    bus16.b         = 16'h4321;
    bus16.cin       = 1'b0;
    bus16.sub       = 1'b0;
    bus16.out_ready = 1'b1;
    bus8.in_valid   = 1'b1;
    bus8.a          = 8'h11;
    bus8.b          = 8'h22;
    bus8.cin        = 1'b0;
    bus8.sub        = 1'b0;
    bus8.out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    #4;
    checkOutput("rst_out_valid", bus16.out_valid, 0);
    checkOutput("rst_sum", bus16.sum, 0);
    checkOutput("rst_cout", bus16.cout, 0);
    checkOutput("rst_ovf", bus16.ovf, 0);
    checkOutput("rst8_out_valid", bus8.out_valid, 0);
`ifdef PIPELINED_ADDER_DBG_EN
    checkOutput("rst_dbg", dbg16, 0);
`endif
    @(negedge clk);
    rst_n          = 1'b1;
    bus16.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
    #4;
    checkOutput("rst_in_ready", bus16.in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitResult(lat);
      e = model16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      checkOutput($sformatf("vec%0d_latency", i), lat, 4);
      checkOutput($sformatf("vec%0d_sum", i), bus16.sum, vecs[i].sum);
      checkOutput($sformatf("vec%0d_cout", i), bus16.cout, vecs[i].cout);
      checkOutput($sformatf("vec%0d_ovf", i), bus16.ovf, vecs[i].ovf);
`ifdef PIPELINED_ADDER_DBG_EN
      checkOutput($sformatf("vec%0d_dbg", i), dbg16, e.dbg);
`endif
    end
`ifdef PIPELINED_ADDER_DBG_EN
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitResult(lat);
    checkOutput("ripple_dbg_all_ones", dbg16, 4'b1111);
`endif

    // Single-stage instance: result valid one edge after acceptance.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ea, eb, es;
      logic       esub, ec, eo;
      case (i)
        0:       begin ea = 8'h7F; eb = 8'h01; esub = 1'b0; es = 8'h80; ec = 1'b0; eo = 1'b1; end
        1:       begin ea = 8'hFF; eb = 8'h01; esub = 1'b0; es = 8'h00; ec = 1'b1; eo = 1'b0; end
        default: begin ea = 8'h10; eb = 8'h20; esub = 1'b1; es = 8'hF0; ec = 1'b0; eo = 1'b0; end
      endcase
      @(negedge clk);
      bus8.a        = ea;
      bus8.b        = eb;
      bus8.cin      = 1'b0;
      bus8.sub      = esub;
      bus8.in_valid = 1'b1;
      #4;
      checkOutput("s8_in_ready", bus8.in_ready, 1);
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
      @(negedge clk);
      #4;
      checkOutput($sformatf("s8_%0d_valid", i), bus8.out_valid, 1);
      checkOutput($sformatf("s8_%0d_sum", i), bus8.sum, es);
      checkOutput($sformatf("s8_%0d_cout", i), bus8.cout, ec);
      checkOutput($sformatf("s8_%0d_ovf", i), bus8.ovf, eo);
    end

    // Reset mid-flight: stall a result at the output, then pulse reset.
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    @(negedge clk);
    bus16.out_ready = 1'b0;
    @(negedge clk);
    #4;
    checkOutput("pre_reset_valid", bus16.out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus16.out_valid, 0);
    checkOutput("midrst_sum", bus16.sum, 0);
    @(negedge clk);
    rst_n           = 1'b1;
    bus16.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #4;
      if (bus16.out_valid) seen++;
    end
    checkOutput("post_reset_stale", seen, 0);

    runStream(8, 0);
    runStream(40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
